// File: rtl/mux_select_bank.sv
// ============================================================================
// Module   : mux_select_bank
// Purpose  : Three independent selectors (2:1, 4:1, 8:1) with registered copies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_select_bank #(
    parameter int W2 = 8,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [W2-1:0] a0,
    input  logic [W2-1:0] a1,
    input  logic          s1,
    input  logic [W-1:0]  b0,
    input  logic [W-1:0]  b1,
    input  logic [W-1:0]  b2,
    input  logic [W-1:0]  b3,
    input  logic [1:0]    s2,
    input  logic [W-1:0]  c0,
    input  logic [W-1:0]  c1,
    input  logic [W-1:0]  c2,
    input  logic [W-1:0]  c3,
    input  logic [W-1:0]  c4,
    input  logic [W-1:0]  c5,
    input  logic [W-1:0]  c6,
    input  logic [W-1:0]  c7,
    input  logic [2:0]    s3,
    output logic [W2-1:0] y1,
    output logic [W-1:0]  y4,
    output logic [W-1:0]  y8,
    output logic [W2-1:0] y1_q,
    output logic [W-1:0]  y4_q,
    output logic [W-1:0]  y8_q
);

    logic [W2-1:0] y1_d;
    logic [W-1:0]  y4_d;
    logic [W-1:0]  y8_d;

    always_comb begin
        y1_d = s1 ? a1 : a0;
    end

    // Every code is covered explicitly; the defaults only satisfy lint.
    always_comb begin
        y4_d = b0;
        case (s2)
            2'd0:    y4_d = b0;
            2'd1:    y4_d = b1;
            2'd2:    y4_d = b2;
            2'd3:    y4_d = b3;
            default: y4_d = b0;
        endcase
    end

    always_comb begin
        y8_d = c0;
        case (s3)
            3'd0:    y8_d = c0;
            3'd1:    y8_d = c1;
            3'd2:    y8_d = c2;
            3'd3:    y8_d = c3;
            3'd4:    y8_d = c4;
            3'd5:    y8_d = c5;
            3'd6:    y8_d = c6;
            3'd7:    y8_d = c7;
            default: y8_d = c0;
        endcase
    end

    assign y1 = y1_d;
    assign y4 = y4_d;
    assign y8 = y8_d;

    // Reset outranks the load enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y1_q <= '0;
            y4_q <= '0;
            y8_q <= '0;
        end else if (en) begin
            y1_q <= y1_d;
            y4_q <= y4_d;
            y8_q <= y8_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_select_bank.sv
// ============================================================================
// Module   : tb_mux_select_bank
// Purpose  : Directed, table-driven checks of mux_select_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_select_bank;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  a0, a1;
    logic        s1;
    logic [31:0] b0, b1, b2, b3;
    logic [1:0]  s2;
    logic [31:0] c0, c1, c2, c3, c4, c5, c6, c7;
    logic [2:0]  s3;
    logic [7:0]  y1, y1_q;
    logic [31:0] y4, y8, y4_q, y8_q;

    int errors = 0;
    int checks = 0;

    mux_select_bank #(.W2(8), .W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a0(a0), .a1(a1), .s1(s1),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .s2(s2),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3),
        .c4(c4), .c5(c5), .c6(c6), .c7(c7), .s3(s3),
        .y1(y1), .y4(y4), .y8(y8),
        .y1_q(y1_q), .y4_q(y4_q), .y8_q(y8_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s1;
        logic [1:0]  s2;
        logic [2:0]  s3;
        logic [7:0]  e1;
        logic [31:0] e4;
        logic [31:0] e8;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a0 = 8'h1f; a1 = 8'h2f;
        b0 = 32'hffff1111; b1 = 32'hffff2222; b2 = 32'hffff3333; b3 = 32'hffff4444;
        c0 = 32'hffff1111; c1 = 32'hffff2222; c2 = 32'hffff3333; c3 = 32'hffff4444;
        c4 = 32'hffff5555; c5 = 32'hffff6666; c6 = 32'hffff7777; c7 = 32'hffff8888;
        rst_n = 1'b0; en = 1'b1;
        s1 = 1'b1; s2 = 2'd3; s3 = 3'd7;

        // s1 sweep, then s2 sweep, then s3 order 0,2,4,1,3,5,6,7
        vecs[0]  = '{1'b0, 2'd0, 3'd0, 8'h1f, 32'hffff1111, 32'hffff1111};
        vecs[1]  = '{1'b1, 2'd0, 3'd0, 8'h2f, 32'hffff1111, 32'hffff1111};
        vecs[2]  = '{1'b0, 2'd0, 3'd0, 8'h1f, 32'hffff1111, 32'hffff1111};
        vecs[3]  = '{1'b0, 2'd1, 3'd0, 8'h1f, 32'hffff2222, 32'hffff1111};
        vecs[4]  = '{1'b0, 2'd2, 3'd0, 8'h1f, 32'hffff3333, 32'hffff1111};
        vecs[5]  = '{1'b0, 2'd3, 3'd0, 8'h1f, 32'hffff4444, 32'hffff1111};
        vecs[6]  = '{1'b0, 2'd0, 3'd0, 8'h1f, 32'hffff1111, 32'hffff1111};
        vecs[7]  = '{1'b0, 2'd0, 3'd2, 8'h1f, 32'hffff1111, 32'hffff3333};
        vecs[8]  = '{1'b0, 2'd0, 3'd4, 8'h1f, 32'hffff1111, 32'hffff5555};
        vecs[9]  = '{1'b0, 2'd0, 3'd1, 8'h1f, 32'hffff1111, 32'hffff2222};
        vecs[10] = '{1'b0, 2'd0, 3'd3, 8'h1f, 32'hffff1111, 32'hffff4444};
        vecs[11] = '{1'b0, 2'd0, 3'd5, 8'h1f, 32'hffff1111, 32'hffff6666};
        vecs[12] = '{1'b0, 2'd0, 3'd6, 8'h1f, 32'hffff1111, 32'hffff7777};
        vecs[13] = '{1'b0, 2'd0, 3'd7, 8'h1f, 32'hffff1111, 32'hffff8888};
        vecs[14] = '{1'b1, 2'd3, 3'd7, 8'h2f, 32'hffff4444, 32'hffff8888};
        vecs[15] = '{1'b1, 2'd2, 3'd5, 8'h2f, 32'hffff3333, 32'hffff6666};

        // Reset held two cycles with en=1: registers clear, comb outputs valid.
        @(negedge clk);
        edge_settle();
        edge_settle();
        chk("rst_y1_q", {24'd0, y1_q}, 32'h0);
        chk("rst_y4_q", y4_q, 32'h0);
        chk("rst_y8_q", y8_q, 32'h0);
        chk("rst_y1", {24'd0, y1}, 32'h2f);
        chk("rst_y4", y4, 32'hffff4444);
        chk("rst_y8", y8, 32'hffff8888);

        @(negedge clk);
        rst_n = 1'b1;
        edge_settle();
        chk("rel_y1_q", {24'd0, y1_q}, 32'h2f);
        chk("rel_y4_q", y4_q, 32'hffff4444);
        chk("rel_y8_q", y8_q, 32'hffff8888);

        // Combinational table
        for (int i = 0; i < 16; i++) begin
            s1 = vecs[i].s1; s2 = vecs[i].s2; s3 = vecs[i].s3;
            #100;
            chk($sformatf("vec%0d_y1", i), {24'd0, y1}, {24'd0, vecs[i].e1});
            chk($sformatf("vec%0d_y4", i), y4, vecs[i].e4);
            chk($sformatf("vec%0d_y8", i), y8, vecs[i].e8);
        end

        // Independence: new b data must move y4 only.
        s1 = 1'b0; s3 = 3'd3;
        b0 = 32'haaaa0000; b1 = 32'haaaa0001; b2 = 32'haaaa0002; b3 = 32'haaaa0003;
        for (int i = 0; i < 4; i++) begin
            s2 = 2'(i);
            #10;
            chk($sformatf("indep_y4_%0d", i), y4, 32'haaaa0000 + 32'(i));
            chk($sformatf("indep_y8_%0d", i), y8, 32'hffff4444);
            chk($sformatf("indep_y1_%0d", i), {24'd0, y1}, 32'h1f);
        end
        b0 = 32'hffff1111; b1 = 32'hffff2222; b2 = 32'hffff3333; b3 = 32'hffff4444;

        // Load then change select: register follows only after the edge.
        @(negedge clk);
        en = 1'b1; s1 = 1'b1; s2 = 2'd0; s3 = 3'd6;
        edge_settle();
        chk("ld_y4_q", y4_q, 32'hffff1111);
        @(negedge clk);
        s2 = 2'd2;
        #1;
        chk("pre_edge_y4_q", y4_q, 32'hffff1111);
        edge_settle();
        chk("post_edge_y4_q", y4_q, 32'hffff3333);
        chk("post_edge_y1_q", {24'd0, y1_q}, 32'h2f);
        chk("post_edge_y8_q", y8_q, 32'hffff7777);

        // Hold with en=0
        @(negedge clk);
        en = 1'b0; s1 = 1'b0; s2 = 2'd3; s3 = 3'd1;
        edge_settle();
        edge_settle();
        chk("hold_y4_q", y4_q, 32'hffff3333);
        chk("hold_y4", y4, 32'hffff4444);
        chk("hold_y1_q", {24'd0, y1_q}, 32'h2f);
        chk("hold_y8_q", y8_q, 32'hffff7777);

        // Reset wins over hold
        @(negedge clk);
        rst_n = 1'b0;
        edge_settle();
        chk("rst2_y1_q", {24'd0, y1_q}, 32'h0);
        chk("rst2_y4_q", y4_q, 32'h0);
        chk("rst2_y8_q", y8_q, 32'h0);
        chk("rst2_y8", y8, 32'hffff2222);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
